poly_tone_gen: RTL and testbench

//  Parametrised multi-channel successor to the single-voice tone generator.

---
 rtl/poly_tone_gen.sv | 127 ++++++++++++
 tb/tb_poly_tone_gen.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_tone_gen.sv
// poly_tone_gen: CH_N independent square-wave voices with per-voice period,
// volume and strobe-driven volume decay. The voices are summed into an
// unsigned mix, and a first-order sigma-delta modulator turns the mix into a
// 1-bit audio stream.
module poly_tone_gen #(
  parameter int CH_N  = 2,
  parameter int BW    = 24,
  parameter int VOL_W = 4,
  parameter int CH_W  = 1,
  parameter int MIX_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             strb_i,
  input  logic             wr_en_i,
  input  logic [CH_W-1:0]  wr_ch_i,
  input  logic [BW-1:0]    wr_period_i,
  input  logic [VOL_W-1:0] wr_vol_i,
  input  logic             wr_decay_i,
  output logic [CH_N-1:0]  active_o,
  output logic [MIX_W-1:0] mix_o,
  output logic             pwm_o
);

  logic [BW-1:0]    r_period [CH_N];
  logic [VOL_W-1:0] r_vol    [CH_N];
  logic             r_decay  [CH_N];
  logic [BW-1:0]    r_cnt    [CH_N];
  logic             r_sq     [CH_N];
  logic [CH_N-1:0]  r_active;
  logic [MIX_W-1:0] r_mix;
  logic [MIX_W-1:0] r_acc;
  logic             r_pwm;

  logic [BW-1:0]    w_periodNext [CH_N];
  logic [VOL_W-1:0] w_volNext    [CH_N];
  logic             w_decayNext  [CH_N];
  logic [BW-1:0]    w_cntNext    [CH_N];
  logic             w_sqNext     [CH_N];
  logic [CH_N-1:0]  w_activeNext;
  logic [MIX_W-1:0] w_mixSum;
  logic [MIX_W:0]   w_sdSum;

  // Per-voice next state: a write reloads the voice and restarts its phase,
  // otherwise the envelope decays on a strobe and the phase counter advances.
  always_comb begin
    for (int c = 0; c < CH_N; c++) begin
      w_periodNext[c] = r_period[c];
      w_volNext[c]    = r_vol[c];
      w_decayNext[c]  = r_decay[c];
      w_cntNext[c]    = r_cnt[c];
      w_sqNext[c]     = r_sq[c];
      if (wr_en_i && (wr_ch_i == CH_W'(c))) begin
        w_periodNext[c] = wr_period_i;
        w_volNext[c]    = wr_vol_i;
        w_decayNext[c]  = wr_decay_i;
        w_cntNext[c]    = '0;
        w_sqNext[c]     = 1'b0;
      end else begin
        if (strb_i && r_decay[c] && (r_vol[c] != '0)) begin
          w_volNext[c] = r_vol[c] - VOL_W'(1);
        end
        if (r_period[c] < BW'(2)) begin
          w_cntNext[c] = '0;
          w_sqNext[c]  = 1'b0;
        end else begin
          if (r_cnt[c] >= (r_period[c] - BW'(1))) begin
            w_cntNext[c] = '0;
          end else begin
            w_cntNext[c] = r_cnt[c] + BW'(1);
          end
          w_sqNext[c] = (w_cntNext[c] < (r_period[c] >> 1));
        end
      end
      w_activeNext[c] = (w_periodNext[c] >= BW'(2)) && (w_volNext[c] != '0);
    end
  end

  // Sum of the sounding voices; full scale always fits in MIX_W bits.
  always_comb begin
    w_mixSum = '0;
    for (int c = 0; c < CH_N; c++) begin
      if (r_sq[c]) begin
        w_mixSum = w_mixSum + MIX_W'(r_vol[c]);
      end
    end
  end

  // Sigma-delta accumulate: the carry out of acc + mix is the output bit.
  always_comb begin
    w_sdSum = {1'b0, r_acc} + {1'b0, r_mix};
  end

  // State registers for all voices, the mixer and the modulator.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < CH_N; c++) begin
        r_period[c] <= '0;
        r_vol[c]    <= '0;
        r_decay[c]  <= 1'b0;
        r_cnt[c]    <= '0;
        r_sq[c]     <= 1'b0;
      end
      r_active <= '0;
      r_mix    <= '0;
      r_acc    <= '0;
      r_pwm    <= 1'b0;
    end else begin
      for (int c = 0; c < CH_N; c++) begin
        r_period[c] <= w_periodNext[c];
        r_vol[c]    <= w_volNext[c];
        r_decay[c]  <= w_decayNext[c];
        r_cnt[c]    <= w_cntNext[c];
        r_sq[c]     <= w_sqNext[c];
      end
      r_active <= w_activeNext;
      r_mix    <= w_mixSum;
      r_acc    <= w_sdSum[MIX_W-1:0];
      r_pwm    <= w_sdSum[MIX_W];
    end
  end

  assign active_o = r_active;
  assign mix_o    = r_mix;
  assign pwm_o    = r_pwm;

endmodule

// File: tb/tb_poly_tone_gen.sv
// tb_poly_tone_gen: directed scenarios followed by random traffic, every
// cycle compared against a behavioural model of the voices, mixer and
// sigma-delta modulator.
module tb_poly_tone_gen;

  localparam int CH_N  = 3;
  localparam int BW    = 24;
  localparam int VOL_W = 4;
  localparam int CH_W  = 2;
  localparam int MIX_W = 6;
  localparam int FULL  = 1 << MIX_W;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             strb_i;
  logic             wr_en_i;
  logic [CH_W-1:0]  wr_ch_i;
  logic [BW-1:0]    wr_period_i;
  logic [VOL_W-1:0] wr_vol_i;
  logic             wr_decay_i;
  logic [CH_N-1:0]  active_o;
  logic [MIX_W-1:0] mix_o;
  logic             pwm_o;

  int vectors = 0;
  int miscompares = 0;

  int mPeriod [CH_N];
  int mVol    [CH_N];
  int mDecay  [CH_N];
  int mPhase  [CH_N];
  int mHigh   [CH_N];
  int mMix;
  int mAcc;
  int mPwm;
  logic [CH_N-1:0] mActive;

  poly_tone_gen #(
    .CH_N (CH_N),
    .BW   (BW),
    .VOL_W(VOL_W),
    .CH_W (CH_W),
    .MIX_W(MIX_W)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .strb_i     (strb_i),
    .wr_en_i    (wr_en_i),
    .wr_ch_i    (wr_ch_i),
    .wr_period_i(wr_period_i),
    .wr_vol_i   (wr_vol_i),
    .wr_decay_i (wr_decay_i),
    .active_o   (active_o),
    .mix_o      (mix_o),
    .pwm_o      (pwm_o)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Advance the reference model by one clock edge using the inputs that the
  // DUT sampled on that edge.
  task automatic modelStep();
    int newMix;
    int sum;
    if (rst_i) begin
      for (int c = 0; c < CH_N; c++) begin
        mPeriod[c] = 0; mVol[c] = 0; mDecay[c] = 0; mPhase[c] = 0; mHigh[c] = 0;
      end
      mMix = 0; mAcc = 0; mPwm = 0; mActive = '0;
      return;
    end
    newMix = 0;
    for (int c = 0; c < CH_N; c++) begin
      if (mHigh[c] != 0) newMix += mVol[c];
    end
    sum  = mAcc + mMix;
    mPwm = (sum >= FULL) ? 1 : 0;
    mAcc = sum % FULL;
    mMix = newMix;
    for (int c = 0; c < CH_N; c++) begin
      if (wr_en_i && (int'(wr_ch_i) == c)) begin
        mPeriod[c] = int'(wr_period_i);
        mVol[c]    = int'(wr_vol_i);
        mDecay[c]  = int'(wr_decay_i);
        mPhase[c]  = 0;
        mHigh[c]   = 0;
      end else begin
        if (strb_i && mDecay[c] != 0 && mVol[c] > 0) mVol[c] = mVol[c] - 1;
        if (mPeriod[c] < 2) begin
          mPhase[c] = 0;
          mHigh[c]  = 0;
        end else begin
          mPhase[c] = (mPhase[c] + 1) % mPeriod[c];
          mHigh[c]  = (mPhase[c] < mPeriod[c] / 2) ? 1 : 0;
        end
      end
      mActive[c] = (mPeriod[c] >= 2) && (mVol[c] != 0);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic checkOutput(string tag);
    vectors++;
    assert (active_o === mActive) else begin
      miscompares++;
      $error("FAIL %s active_o got %0h expected %0h", tag, active_o, mActive);
    end
    vectors++;
    assert (mix_o === MIX_W'(mMix)) else begin
      miscompares++;
      $error("FAIL %s mix_o got %0d expected %0d", tag, mix_o, mMix);
    end
    vectors++;
    assert (pwm_o === 1'(mPwm)) else begin
      miscompares++;
      $error("FAIL %s pwm_o got %0d expected %0d", tag, pwm_o, mPwm);
    end
  endtask

  // Directed comparison against a hand-derived value.
  task automatic checkValue(string tag, int got, int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model and compare.
  task automatic applyStimulus(string tag, logic rst, logic strb, logic we,
                               int ch, int period, int vol, logic decay);
    rst_i       = rst;
    strb_i      = strb;
    wr_en_i     = we;
    wr_ch_i     = CH_W'(ch);
    wr_period_i = BW'(period);
    wr_vol_i    = VOL_W'(vol);
    wr_decay_i  = decay;
    @(posedge clk_i);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(string tag, int n);
    repeat (n) applyStimulus(tag, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  // Directed scenarios followed by random traffic.
  initial begin
    int cnt15;
    int cnt0;
    int maxMix;
    logic seen30;
    logic allInSet;

    $display("[TB] poly_tone_gen bench start");
    for (int c = 0; c < CH_N; c++) begin
      mPeriod[c] = 0; mVol[c] = 0; mDecay[c] = 0; mPhase[c] = 0; mHigh[c] = 0;
    end
    mMix = 0; mAcc = 0; mPwm = 0; mActive = '0;

    applyStimulus("reset", 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    applyStimulus("reset", 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    checkValue("reset_mix", int'(mix_o), 0);
    checkValue("reset_active", int'(active_o), 0);
    checkValue("reset_pwm", int'(pwm_o), 0);

    // Single voice, period 8, full volume: steady 4 high / 4 low.
    applyStimulus("t1_write", 1'b0, 1'b0, 1'b1, 0, 8, 15, 1'b0);
    checkValue("t1_active", int'(active_o), 1);
    idle("t1_run", 20);
    cnt15 = 0; cnt0 = 0;
    for (int i = 0; i < 16; i++) begin
      idle("t1_win", 1);
      if (mix_o == 6'd15) cnt15++;
      if (mix_o == 6'd0)  cnt0++;
    end
    checkValue("t1_mix15_count", cnt15, 8);
    checkValue("t1_mix0_count", cnt0, 8);

    // Decaying voice: volume 3 reaches 0 on the third strobe.
    applyStimulus("t2_write", 1'b0, 1'b0, 1'b1, 0, 4, 3, 1'b1);
    idle("t2_run", 4);
    for (int p = 1; p <= 5; p++) begin
      applyStimulus("t2_strobe", 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
      if (p == 2) checkValue("t2_active_after2", int'(active_o[0]), 1);
      if (p == 3) checkValue("t2_active_after3", int'(active_o[0]), 0);
      idle("t2_gap", 2);
    end
    maxMix = 0;
    for (int i = 0; i < 10; i++) begin
      idle("t2_quiet", 1);
      if (int'(mix_o) > maxMix) maxMix = int'(mix_o);
    end
    checkValue("t2_mix_silent", maxMix, 0);

    // Two aligned voices peak at 30; then a period-4 beat gives 0/15/30.
    applyStimulus("t3_w1", 1'b0, 1'b0, 1'b1, 1, 6, 15, 1'b0);
    idle("t3_align", 5);
    applyStimulus("t3_w0", 1'b0, 1'b0, 1'b1, 0, 6, 15, 1'b0);
    idle("t3_settle", 3);
    maxMix = 0;
    for (int i = 0; i < 30; i++) begin
      idle("t3_run", 1);
      if (int'(mix_o) > maxMix) maxMix = int'(mix_o);
    end
    checkValue("t3_peak", maxMix, 30);
    applyStimulus("t3_w1b", 1'b0, 1'b0, 1'b1, 1, 4, 15, 1'b0);
    idle("t3_settle2", 3);
    seen30 = 1'b0; allInSet = 1'b1;
    for (int i = 0; i < 24; i++) begin
      idle("t3_beat", 1);
      if (mix_o == 6'd30) seen30 = 1'b1;
      if (!(mix_o == 6'd0 || mix_o == 6'd15 || mix_o == 6'd30)) allInSet = 1'b0;
    end
    checkValue("t3_beat_seen30", int'(seen30), 1);
    checkValue("t3_beat_values", int'(allInSet), 1);

    // Short periods mute; out-of-range channel writes change nothing.
    applyStimulus("t4_w0", 1'b0, 1'b0, 1'b1, 0, 1, 15, 1'b0);
    applyStimulus("t4_w1", 1'b0, 1'b0, 1'b1, 1, 0, 15, 1'b0);
    idle("t4_run", 4);
    checkValue("t4_active_mute", int'(active_o), 0);
    checkValue("t4_mix_mute", int'(mix_o), 0);
    applyStimulus("t4_wbad", 1'b0, 1'b0, 1'b1, 3, 8, 15, 1'b0);
    idle("t4_run2", 10);
    checkValue("t4_active_bad", int'(active_o), 0);
    checkValue("t4_mix_bad", int'(mix_o), 0);

    // Write collides with strobe: loaded volume 9 survives, next strobe gives 8.
    applyStimulus("t5_wstrb", 1'b0, 1'b1, 1'b1, 0, 4, 9, 1'b1);
    maxMix = 0;
    for (int i = 0; i < 8; i++) begin
      idle("t5_run", 1);
      if (int'(mix_o) > maxMix) maxMix = int'(mix_o);
    end
    checkValue("t5_vol9", maxMix, 9);
    applyStimulus("t5_strobe", 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    idle("t5_settle", 2);
    maxMix = 0;
    for (int i = 0; i < 8; i++) begin
      idle("t5_run2", 1);
      if (int'(mix_o) > maxMix) maxMix = int'(mix_o);
    end
    checkValue("t5_vol8", maxMix, 8);

    // Mid-tone reset silences everything and nothing comes back.
    applyStimulus("t6_w0", 1'b0, 1'b0, 1'b1, 0, 6, 12, 1'b0);
    idle("t6_run", 7);
    applyStimulus("t6_reset", 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    checkValue("t6_mix", int'(mix_o), 0);
    checkValue("t6_active", int'(active_o), 0);
    checkValue("t6_pwm", int'(pwm_o), 0);
    maxMix = 0;
    for (int i = 0; i < 20; i++) begin
      idle("t6_quiet", 1);
      if (int'(mix_o) > maxMix) maxMix = int'(mix_o);
    end
    checkValue("t6_silent", maxMix, 0);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      applyStimulus("random",
                    ($urandom_range(0, 99) < 2),
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 12)),
                    int'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
